// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_tx-side signals around uart_tx_arbiter.
// The arbiter takes the slave view; the board/bench environment takes the master view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   o_done;
  logic               o_busy;
  logic [GW-1:0]      o_grant_idx;
  logic               o_uart_clk;
  logic [7:0]         o_tx_data;
  logic               o_tx_data_w;
  logic               i_tx_ack;
  logic               o_tx_ack_clr;

  modport slave (
    input  i_req, i_req_data, i_tx_ack,
    output o_done, o_busy, o_grant_idx, o_uart_clk, o_tx_data, o_tx_data_w, o_tx_ack_clr
  );

  modport master (
    output i_req, i_req_data, i_tx_ack,
    input  o_done, o_busy, o_grant_idx, o_uart_clk, o_tx_data, o_tx_data_w, o_tx_ack_clr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte sources, running the
// write/ack/ack-clear handshake for them and generating the uart serial clock.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 434
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               uart_clk_q, uart_clk_d;
  logic               ack_meta_q, ack_s_q;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_idx_q, grant_idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_data_w_q, tx_data_w_d;
  logic               ack_clr_q, ack_clr_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   done_onehot;
  logic               win_found;
  logic [GW-1:0]      win_idx;
  int                 cand;

  // Baud generator: uart_clk is registered from the next counter value.
  always_comb begin
    div_d      = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    uart_clk_d = (div_d >= DIV_HALF);
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_q) + i) % N_REQ;
      if (!win_found && bus.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign done_onehot[gi] = (int'(grant_idx_q) == gi);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = SEND;
      SEND:    if (ack_s_q)   state_d = CLEAR;
      CLEAR:   if (!ack_s_q)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic, computed from the upcoming state so every output is a flop.
  always_comb begin
    last_d      = last_q;
    grant_idx_d = grant_idx_q;
    tx_data_d   = tx_data_q;
    if (state_q == IDLE && win_found) begin
      last_d      = win_idx;
      grant_idx_d = win_idx;
      tx_data_d   = bus.i_req_data[int'(win_idx)*8 +: 8];
    end
    tx_data_w_d = (state_d == SEND);
    ack_clr_d   = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == SEND && state_d == CLEAR) ? done_onehot : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q       <= '0;
      uart_clk_q  <= 1'b0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
      last_q      <= GW'(N_REQ - 1);
      grant_idx_q <= '0;
      tx_data_q   <= '0;
      tx_data_w_q <= 1'b0;
      ack_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      div_q       <= div_d;
      uart_clk_q  <= uart_clk_d;
      ack_meta_q  <= bus.i_tx_ack;
      ack_s_q     <= ack_meta_q;
      last_q      <= last_d;
      grant_idx_q <= grant_idx_d;
      tx_data_q   <= tx_data_d;
      tx_data_w_q <= tx_data_w_d;
      ack_clr_q   <= ack_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_done       = done_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_grant_idx  = grant_idx_q;
  assign bus.o_uart_clk   = uart_clk_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_data_w  = tx_data_w_q;
  assign bus.o_tx_ack_clr = ack_clr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx model
// answering the write/ack/ack-clear handshake.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int DIV = 434;

  localparam int W_HI   = 0;
  localparam int ACK_HI = 1;
  localparam int ACK_LO = 2;
  localparam int IDLE_C = 3;
  localparam int DONE_K = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .CLK_DIV(DIV)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // uart_tx model: acks ack_dly cycles after a write, drops ack clr_dly cycles after ack-clear.
  int         ack_dly = 5;
  int         clr_dly = 4;
  int         m_state = 0;
  int         m_cnt   = 0;
  logic [7:0] m_byte  = 8'h00;
  logic [7:0] log_q[$];
  int         hold_err  = 0;
  int         stray_clr = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state      = 0;
      bus.i_tx_ack = 1'b0;
    end else begin
      case (m_state)
        0: begin
          if (bus.o_tx_ack_clr) stray_clr++;
          if (bus.o_tx_data_w) begin
            m_byte  = bus.o_tx_data;
            m_cnt   = ack_dly;
            m_state = 1;
          end
        end
        1: begin
          if (bus.o_tx_ack_clr) stray_clr++;
          if (!bus.o_tx_data_w) begin
            m_state = 0;
          end else begin
            if (bus.o_tx_data !== m_byte) hold_err++;
            m_cnt--;
            if (m_cnt <= 0) begin
              bus.i_tx_ack = 1'b1;
              log_q.push_back(m_byte);
              m_state = 2;
            end
          end
        end
        2: if (bus.o_tx_ack_clr) begin
          m_cnt   = clr_dly;
          m_state = 3;
        end
        3: begin
          m_cnt--;
          if (m_cnt <= 0) begin
            bus.i_tx_ack = 1'b0;
            m_state      = 4;
          end
        end
        default: if (!bus.o_tx_ack_clr) m_state = 0;
      endcase
    end
  end

  // Cycles each o_done bit spends high
  int done_cyc[N];
  initial for (int k = 0; k < N; k++) done_cyc[k] = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) if (bus.o_done[k]) done_cyc[k]++;
    end
  end

  // uart_clk edge times (negedges after the first reset release)
  int   cyc = 0;
  logic prev_uc = 1'b0;
  int   rise1 = -1, fall1 = -1, rise2 = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc     = 0;
      prev_uc = 1'b0;
    end else begin
      cyc++;
      if (bus.o_uart_clk && !prev_uc && rise1 < 0) rise1 = cyc;
      else if (!bus.o_uart_clk && prev_uc && rise1 >= 0 && fall1 < 0) fall1 = cyc;
      else if (bus.o_uart_clk && !prev_uc && fall1 >= 0 && rise2 < 0) rise2 = cyc;
      prev_uc = bus.o_uart_clk;
    end
  end

  task automatic wait_cond(input int which, input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      case (which)
        W_HI:    ok = bus.o_tx_data_w;
        ACK_HI:  ok = bus.i_tx_ack;
        ACK_LO:  ok = !bus.i_tx_ack;
        IDLE_C:  ok = !bus.o_busy;
        default: ok = bus.o_done[which-DONE_K];
      endcase
      if (ok) break;
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0, d2;

    // Reset with every request asserted
    bus.i_req      = 3'b111;
    bus.i_req_data = {8'h43, 8'h42, 8'h41};
    repeat (3) step();
    chk("rst_done",     32'(bus.o_done), 32'h0);
    chk("rst_busy",     32'(bus.o_busy), 32'h0);
    chk("rst_idx",      32'(bus.o_grant_idx), 32'h0);
    chk("rst_uart_clk", 32'(bus.o_uart_clk), 32'h0);
    chk("rst_tx_data",  32'(bus.o_tx_data), 32'h0);
    chk("rst_tx_w",     32'(bus.o_tx_data_w), 32'h0);
    chk("rst_ack_clr",  32'(bus.o_tx_ack_clr), 32'h0);
    rst_n = 1'b1;
    step();
    chk("first_tx_w", 32'(bus.o_tx_data_w), 32'h1);
    chk("first_busy", 32'(bus.o_busy), 32'h1);
    chk("first_idx",  32'(bus.o_grant_idx), 32'h0);
    chk("first_data", 32'(bus.o_tx_data), 32'h41);

    // Contention: all three held high for six bytes
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done_cyc[0] + done_cyc[1] + done_cyc[2] >= 6) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    bus.i_req = 3'b000;
    chk("cont_six_done", 32'(ok), 32'h1);
    wait_cond(IDLE_C, 100, ok);
    chk("cont_idle", 32'(ok), 32'h1);
    repeat (5) step();
    chk("cont_stay_idle", 32'(bus.o_busy), 32'h0);
    chk("cont_log_len", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk($sformatf("cont_byte%0d", i), 32'(log_q[i]), 32'h41 + 32'(i % 3));
    for (int k = 0; k < N; k++)
      chk($sformatf("cont_done_cyc%0d", k), 32'(done_cyc[k]), 32'd2);

    // Single byte from requester 1, slow ack
    log_q.delete();
    ack_dly        = 1000;
    bus.i_req_data = {8'h00, 8'h5A, 8'h00};
    bus.i_req      = 3'b010;
    wait_cond(W_HI, 10, ok);
    chk("single_grant", 32'(ok), 32'h1);
    chk("single_idx",  32'(bus.o_grant_idx), 32'h1);
    chk("single_data", 32'(bus.o_tx_data), 32'h5A);
    wait_cond(ACK_HI, 1100, ok);
    chk("single_ack", 32'(ok), 32'h1);
    step();
    chk("single_done_e1", 32'(bus.o_done), 32'h0);
    step();
    chk("single_done_e2", 32'(bus.o_done), 32'h0);
    step();
    chk("single_done_e3", 32'(bus.o_done), 32'h2);
    chk("single_w_fall",  32'(bus.o_tx_data_w), 32'h0);
    chk("single_clr_on",  32'(bus.o_tx_ack_clr), 32'h1);
    bus.i_req = 3'b000;
    step();
    chk("single_done_e4", 32'(bus.o_done), 32'h0);
    wait_cond(ACK_LO, 100, ok);
    chk("single_ack_drop", 32'(ok), 32'h1);
    step();
    chk("single_clr_e1", 32'(bus.o_tx_ack_clr), 32'h1);
    step();
    chk("single_clr_e2", 32'(bus.o_tx_ack_clr), 32'h1);
    step();
    chk("single_clr_e3", 32'(bus.o_tx_ack_clr), 32'h0);
    chk("single_busy_e3", 32'(bus.o_busy), 32'h0);
    chk("single_log_len", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("single_log_byte", 32'(log_q[0]), 32'h5A);

    // Withdrawal: one-cycle request from 0 while 1 is being served
    log_q.delete();
    ack_dly        = 20;
    d0             = done_cyc[0];
    bus.i_req_data = {8'h00, 8'h3C, 8'h99};
    bus.i_req      = 3'b010;
    wait_cond(W_HI, 10, ok);
    chk("wd_grant", 32'(ok), 32'h1);
    step();
    bus.i_req = 3'b011;
    step();
    bus.i_req = 3'b010;
    wait_cond(DONE_K + 1, 100, ok);
    chk("wd_done1", 32'(ok), 32'h1);
    bus.i_req = 3'b000;
    wait_cond(IDLE_C, 100, ok);
    chk("wd_idle", 32'(ok), 32'h1);
    repeat (5) step();
    chk("wd_no_done0", 32'(done_cyc[0] - d0), 32'h0);
    chk("wd_idx",      32'(bus.o_grant_idx), 32'h1);
    chk("wd_busy",     32'(bus.o_busy), 32'h0);
    chk("wd_log_len",  32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("wd_log_byte", 32'(log_q[0]), 32'h3C);

    // Reset during SEND, then retry
    log_q.delete();
    ack_dly        = 50;
    bus.i_req_data = {8'h77, 8'h00, 8'h11};
    bus.i_req      = 3'b100;
    wait_cond(W_HI, 10, ok);
    chk("mr_grant", 32'(ok), 32'h1);
    chk("mr_idx2",  32'(bus.o_grant_idx), 32'h2);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_w",    32'(bus.o_tx_data_w), 32'h0);
    chk("mr_async_busy", 32'(bus.o_busy), 32'h0);
    chk("mr_async_idx",  32'(bus.o_grant_idx), 32'h0);
    d2        = done_cyc[2];
    bus.i_req = 3'b101;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("mr_retry_w",    32'(bus.o_tx_data_w), 32'h1);
    chk("mr_retry_idx",  32'(bus.o_grant_idx), 32'h0);
    chk("mr_retry_data", 32'(bus.o_tx_data), 32'h11);
    wait_cond(DONE_K + 0, 200, ok);
    chk("mr_done0", 32'(ok), 32'h1);
    bus.i_req = 3'b100;
    wait_cond(DONE_K + 2, 200, ok);
    chk("mr_done2", 32'(ok), 32'h1);
    bus.i_req = 3'b000;
    wait_cond(IDLE_C, 100, ok);
    chk("mr_idle", 32'(ok), 32'h1);
    chk("mr_done2_once", 32'(done_cyc[2] - d2), 32'h1);
    chk("mr_log_len", 32'(log_q.size()), 32'd2);
    if (log_q.size() > 1) begin
      chk("mr_log0", 32'(log_q[0]), 32'h11);
      chk("mr_log1", 32'(log_q[1]), 32'h77);
    end
    chk("stray_ack_clr", 32'(stray_clr), 32'h0);
    chk("data_hold_err", 32'(hold_err), 32'h0);

    // Baud generator edges captured after the first reset release
    chk("baud_first_rise", 32'(rise1), 32'd217);
    chk("baud_high_len",   32'(fall1 - rise1), 32'd217);
    chk("baud_period",     32'(rise2 - rise1), 32'd434);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `N_REQ` byte sources on the board, and generates the transmitter's slow serial clock. Requesters get access in round-robin order. The block sequences the full four-phase write/ack/ack-clear handshake of `uart_tx` on their behalf. It sits between board-level byte producers (front-panel keys, status reporters, debug monitors) and the single `uart_tx` instance.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 1..8.
- `CLK_DIV`, default 434: `i_clk` cycles per `o_uart_clk` period, ≥ 4.

Ports:
- `i_clk`  in  1  system clock; the only clock in the block.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_req`  in  N_REQ  per-requester byte request (level).
- `i_req_data`  in  8*N_REQ  byte for requester k on bits [8k+7:8k].
- `o_done`  out  N_REQ  one-cycle pulse: requester k's byte was accepted by `uart_tx`.
- `o_busy`  out  1  a handshake is in progress (state ≠ IDLE).
- `o_grant_idx`  out  $clog2(N_REQ) (min 1)  index of the current/last granted requester.
- `o_uart_clk`  out  1  serial clock to `uart_tx`.
- `o_tx_data`  out  8  byte to `uart_tx`.
- `o_tx_data_w`  out  1  write strobe (level) to `uart_tx`.
- `i_tx_ack`  in  1  ack from `uart_tx`, asynchronous to `i_clk`.
- `o_tx_ack_clr`  out  1  ack-clear to `uart_tx`.

## Operation

Baud generator:
- Counter `div` runs 0..CLK_DIV-1 and wraps.
- `o_uart_clk` is registered: 1 when the next `div` ≥ CLK_DIV/2 (integer divide), else 0.
- Period is exactly CLK_DIV cycles; the high phase lasts CLK_DIV − CLK_DIV/2 cycles.
- Free-running; independent of the FSM.

Ack synchronizer:
- `i_tx_ack` passes through 2 flops to give `ack_s`.
- The FSM uses only `ack_s`.

Arbitration:
- Round-robin pointer `last` resets to N_REQ−1, so requester 0 wins first.
- In IDLE, the winner is the first k with `i_req[k]`=1, searching from `last`+1 (mod N_REQ) upward.
- On grant:
  - `o_tx_data` ← that requester's byte.
  - `o_grant_idx` ← k.
  - `last` ← k.

FSM:
- IDLE:
  - any `i_req` → SEND next cycle, with the grant latched.
  - otherwise stay in IDLE.
- SEND:
  - `o_tx_data_w`=1; `o_tx_data` is held constant.
  - `ack_s`=1 → CLEAR.
- CLEAR:
  - `o_tx_data_w`=0, `o_tx_ack_clr`=1.
  - `ack_s`=0 → IDLE, and `o_tx_ack_clr` drops.

Done pulse:
- `o_done[o_grant_idx]` pulses for exactly the first cycle of CLEAR.
- The pulse coincides with `o_tx_data_w` falling.

Requester contract:
- Hold `i_req[k]` and the byte stable from assertion until `o_done[k]`.
- Deasserting before the grant withdraws the request, with no side effects.
- After `o_done[k]`, either drop `i_req[k]` or present the next byte. A `i_req[k]` still high on return to IDLE is treated as a new byte.
- Deasserting `i_req[k]` after the grant has no effect; the byte still completes.

## Timing
- Reset values:
  - `o_done`=0, `o_busy`=0, `o_grant_idx`=0.
  - `o_uart_clk`=0, `o_tx_data`=0, `o_tx_data_w`=0, `o_tx_ack_clr`=0.
  - `div`=0, synchronizer flops=0, state=IDLE.
- All outputs are registered.
- Grant latency: `i_req` high in IDLE at cycle t → `o_tx_data_w`=1 and `o_busy`=1 at t+1.
- Ack latency: `i_tx_ack` rising is visible as `ack_s` after 2 edges → CLEAR on the next edge.
- Minimum occupancy per byte: 1 IDLE + SEND ≥ 3 + CLEAR ≥ 3 cycles.
- Back-to-back bytes: returning to IDLE costs 1 cycle. The winner is evaluated that cycle and SEND follows on the next.
- Simultaneous requests are served strictly in rotation. No requester waits more than N_REQ−1 other grants.
- `ack_s` already 1 on entry to SEND (stale ack): treated as ack, and the FSM enters CLEAR next cycle. `uart_tx` guarantees this cannot happen after a correct clear.
- Reset asserted mid-handshake:
  - Outputs clear immediately (asynchronous).
  - The pending byte is dropped with no `o_done`.
  - Requesters retry after reset.

## Test plan
- Reset: hold `i_reset_n`=0 with `i_req`=all 1s → every output 0; release → first grant to idx 0, and `o_tx_data_w` rises 1 cycle after release.
- Baud, CLK_DIV=434: `o_uart_clk` period 434 cycles, high 217 / low 217, first rising edge 217 cycles after reset release.
- Single byte: requester 1 sends 8'h5A; bench `uart_tx` model acks after 1000 cycles → `o_tx_data`=8'h5A held throughout SEND; `o_done`=2'b10 for 1 cycle, 3 cycles after ack rises; `o_tx_ack_clr` high until 2 cycles after the model drops ack.
- Contention, N_REQ=3: all requesters held high with bytes 8'h41/42/43, re-presenting on each done → UART byte order 41,42,43,41,…; each `o_done` bit pulses once per byte.
- Withdrawal: requester 0 pulses `i_req` for 1 cycle while busy serving requester 1 → no grant to 0 and no `o_done[0]`.
- Mid-handshake reset: assert reset during SEND → `o_tx_data_w` low within the same cycle (async); after release, the model sees no stray ack-clear and the next grant starts at idx 0.
